// File: rtl/pipe_pkg.sv
// Shared pipeline types for the RV32 hazard unit.
// Holds forwarding selects, hazard FSM states and x0 index.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit bus: register indices and control bits in,
// stall/flush/forward selects and perf counters out.
interface hazard_unit_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rs1_e;
  logic [4:0]       rs2_e;
  logic [4:0]       rd_e;
  logic             mem_read_e;
  logic             pc_src_e;
  logic [4:0]       rd_m;
  logic             reg_write_m;
  logic [4:0]       rd_w;
  logic             reg_write_w;
  logic             mem_req_m;
  logic             mem_ready_m;

  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic [1:0]       forward_a_e;
  logic [1:0]       forward_b_e;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e,
    input  mem_read_e, pc_src_e,
    input  rd_m, reg_write_m, rd_w, reg_write_w,
    input  mem_req_m, mem_ready_m,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w,
    output forward_a_e, forward_b_e,
    output mem_timeout, stall_cycles, flush_count
  );

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e,
    output mem_read_e, pc_src_e,
    output rd_m, reg_write_m, rd_w, reg_write_w,
    output mem_req_m, mem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w,
    input  forward_a_e, forward_b_e,
    input  mem_timeout, stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// Operand forwarding select for one E-stage source register.
// Ports: rs, rd_m/reg_write_m, rd_w/reg_write_w in; sel out.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m && (rd_m != REG_X0)
              && (rd_m == rs);
  assign hit_w = reg_write_w && (rd_w != REG_X0)
              && (rd_w == rs);

  // M is younger than W, so its value wins
  always_comb begin
    sel = FWD_RF;
    if (hit_m)      sel = FWD_MEM;
    else if (hit_w) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// 5-stage RV32 hazard control: stalls, flushes, forwarding,
// memory-wait watchdog and saturating perf counters.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_unit_if.slave hz
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  hz_state_t  state;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic     mem_stall;
  logic     load_use;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  assign mem_stall = hz.mem_req_m & ~hz.mem_ready_m;

  assign load_use = hz.mem_read_e
                 && (hz.rd_e != REG_X0)
                 && ((hz.rd_e == hz.rs1_d)
                  || (hz.rd_e == hz.rs2_d));

  fwd_sel u_fwd_a (
    .rs          (hz.rs1_e),
    .rd_m        (hz.rd_m),
    .reg_write_m (hz.reg_write_m),
    .rd_w        (hz.rd_w),
    .reg_write_w (hz.reg_write_w),
    .sel         (sel_a)
  );

  fwd_sel u_fwd_b (
    .rs          (hz.rs2_e),
    .rd_m        (hz.rd_m),
    .reg_write_m (hz.reg_write_m),
    .rd_w        (hz.rd_w),
    .reg_write_w (hz.reg_write_w),
    .sel         (sel_b)
  );

  // A pending redirect is held off while memory freezes E;
  // a redirect also kills a load-use stall on a wrong-path D.
  always_comb begin
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.stall_e = 1'b0;
    hz.stall_m = 1'b0;
    hz.flush_d = 1'b0;
    hz.flush_e = 1'b0;
    hz.flush_w = 1'b0;
    if (rst) begin
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
      hz.flush_w = 1'b1;
    end else if (mem_stall) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.stall_e = 1'b1;
      hz.stall_m = 1'b1;
      hz.flush_w = 1'b1;
    end else if (hz.pc_src_e) begin
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
    end else if (load_use) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.flush_e = 1'b1;
    end
  end

  assign hz.forward_a_e = rst ? FWD_RF : sel_a;
  assign hz.forward_b_e = rst ? FWD_RF : sel_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= WAIT;
            wait_cnt <= 8'd1;
          end
        end
        WAIT: begin
          if (mem_stall) begin
            if (wait_cnt == MAX_CNT) timeout <= 1'b1;
            else wait_cnt <= wait_cnt + 8'd1;
          end else begin
            // ready, or request withdrawn
            state    <= RUN;
            wait_cnt <= 8'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.stall_f && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (hz.pc_src_e && !mem_stall && !(&flush_cnt))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.mem_timeout  = timeout;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_count  = flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed cases then
// random traffic against a rule-level reference model.
module tb_hazard_unit;
  import pipe_pkg::*;

  localparam int MAX_WAIT = 3;
  localparam int CNT_W    = 8;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(CNT_W)) hz();

  hazard_unit #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int checks   = 0;
  int failures = 0;

  // model state
  int m_run;
  bit m_tmo;
  int m_sc;
  int m_fc;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(logic [4:0] rs);
    if (hz.reg_write_m && hz.rd_m != 0 && hz.rd_m == rs)
      return 2'b10;
    if (hz.reg_write_w && hz.rd_w != 0 && hz.rd_w == rs)
      return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_ms();
    return hz.mem_req_m && !hz.mem_ready_m;
  endfunction

  function automatic bit ref_lu();
    return hz.mem_read_e && hz.rd_e != 0
      && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
  endfunction

  // {stall_f,d,e,m, flush_d,e,w}
  function automatic logic [6:0] ref_ctl();
    if (rst)          return 7'b0000_111;
    if (ref_ms())     return 7'b1111_001;
    if (hz.pc_src_e)  return 7'b0000_110;
    if (ref_lu())     return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  task automatic check_comb();
    logic [6:0] got;
    got = {hz.stall_f, hz.stall_d, hz.stall_e,
           hz.stall_m, hz.flush_d, hz.flush_e,
           hz.flush_w};
    chk("ctl", 32'(got), 32'(ref_ctl()));
    chk("fwd_a", 32'(hz.forward_a_e),
        rst ? 32'd0 : 32'(ref_fwd(hz.rs1_e)));
    chk("fwd_b", 32'(hz.forward_b_e),
        rst ? 32'd0 : 32'(ref_fwd(hz.rs2_e)));
  endtask

  task automatic model_edge();
    bit ms;
    bit sf;
    ms = ref_ms();
    sf = !rst && (ms || (!hz.pc_src_e && ref_lu()));
    if (rst) begin
      m_run = 0;
      m_tmo = 1'b0;
      m_sc  = 0;
      m_fc  = 0;
    end else begin
      if (sf && m_sc < CMAX) m_sc++;
      if (hz.pc_src_e && !ms && m_fc < CMAX) m_fc++;
      // timeout once the stall has run past MAX_WAIT edges
      if (ms) begin
        if (m_run >= MAX_WAIT) m_tmo = 1'b1;
        m_run++;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step();
    #1 check_comb();
    @(posedge clk);
    model_edge();
    #1;
    chk("timeout", 32'(hz.mem_timeout), 32'(m_tmo));
    chk("stall_cycles", 32'(hz.stall_cycles), 32'(m_sc));
    chk("flush_count", 32'(hz.flush_count), 32'(m_fc));
  endtask

  task automatic idle();
    hz.rs1_d = 0; hz.rs2_d = 0;
    hz.rs1_e = 0; hz.rs2_e = 0;
    hz.rd_e = 0;  hz.mem_read_e = 0;
    hz.pc_src_e = 0;
    hz.rd_m = 0;  hz.reg_write_m = 0;
    hz.rd_w = 0;  hz.reg_write_w = 0;
    hz.mem_req_m = 0; hz.mem_ready_m = 0;
  endtask

  initial begin
    m_run = 0; m_tmo = 0; m_sc = 0; m_fc = 0;
    idle();
    rst = 1'b1;

    // reset
    step();
    step();
    chk("rst_fw", 32'(hz.flush_w), 32'd1);
    chk("rst_sf", 32'(hz.stall_f), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_sc", 32'(hz.stall_cycles), 32'd0);

    // load-use
    hz.mem_read_e = 1; hz.rd_e = 5; hz.rs2_d = 5;
    #1;
    chk("lu_sf", 32'(hz.stall_f), 32'd1);
    chk("lu_fe", 32'(hz.flush_e), 32'd1);
    step();
    chk("lu_cnt", 32'(hz.stall_cycles), 32'd1);

    // branch over load-use
    hz.pc_src_e = 1;
    #1;
    chk("br_fd", 32'(hz.flush_d), 32'd1);
    chk("br_sf", 32'(hz.stall_f), 32'd0);
    step();
    chk("br_cnt", 32'(hz.flush_count), 32'd1);
    idle();

    // forwarding priority
    hz.rs1_e = 7; hz.rd_m = 7; hz.reg_write_m = 1;
    hz.rd_w = 7; hz.reg_write_w = 1;
    #1 chk("fwd_mem", 32'(hz.forward_a_e), 32'd2);
    step();
    hz.rd_m = 0;
    #1 chk("fwd_wb", 32'(hz.forward_a_e), 32'd1);
    step();
    hz.reg_write_w = 0;
    #1 chk("fwd_rf", 32'(hz.forward_a_e), 32'd0);
    step();
    idle();

    // memory wait, redirect held until release
    hz.mem_req_m = 1; hz.pc_src_e = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_sm", 32'(hz.stall_m), 32'd1);
      chk("mw_fw", 32'(hz.flush_w), 32'd1);
      chk("mw_fd", 32'(hz.flush_d), 32'd0);
      step();
    end
    chk("mw_fc_hold", 32'(hz.flush_count), 32'd1);
    hz.mem_ready_m = 1;
    #1 chk("mw_rel", 32'(hz.stall_m), 32'd0);
    step();
    chk("mw_fc_rel", 32'(hz.flush_count), 32'd2);
    idle();

    // watchdog
    rst = 1; step(); rst = 0;
    hz.mem_req_m = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("wd_tmo", 32'(hz.mem_timeout), 32'(k >= 4));
    end
    hz.mem_ready_m = 1;
    step();
    chk("wd_sticky", 32'(hz.mem_timeout), 32'd1);
    rst = 1; step(); rst = 0;
    chk("wd_clr", 32'(hz.mem_timeout), 32'd0);
    idle();

    // reset mid-wait
    hz.mem_req_m = 1;
    step(); step();
    rst = 1;
    #1;
    chk("rw_fw", 32'(hz.flush_w), 32'd1);
    chk("rw_sm", 32'(hz.stall_m), 32'd0);
    step();
    rst = 0;
    idle();
    step();
    chk("rw_state", 32'(dut.state), 32'(RUN));
    chk("rw_sc", 32'(hz.stall_cycles), 32'd0);
    chk("rw_to", 32'(hz.mem_timeout), 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      hz.rs1_d = 5'($urandom_range(0, 3));
      hz.rs2_d = 5'($urandom_range(0, 3));
      hz.rs1_e = 5'($urandom_range(0, 3));
      hz.rs2_e = 5'($urandom_range(0, 3));
      hz.rd_e  = 5'($urandom_range(0, 3));
      hz.rd_m  = 5'($urandom_range(0, 3));
      hz.rd_w  = 5'($urandom_range(0, 3));
      hz.mem_read_e  = 1'($urandom_range(0, 1));
      hz.reg_write_m = 1'($urandom_range(0, 1));
      hz.reg_write_w = 1'($urandom_range(0, 1));
      hz.pc_src_e    = ($urandom_range(0, 4) == 0);
      hz.mem_req_m   = ($urandom_range(0, 2) == 0);
      hz.mem_ready_m = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
